// File: rtl/traffic_light.sv
`timescale 1ns/1ps
// Two-direction traffic light: fixed six-phase cycle (green/yellow/all-red per direction).
// Latency: lamps are decoded from the state register and change only on the phase-transition edge.
// Backpressure: none; free-running. Async active-low reset restarts at S0 with the dwell counter cleared.
module traffic_light #(
  parameter int unsigned GREEN_CYCLES   = 480000000,
  parameter int unsigned YELLOW_CYCLES  = 80000000,
  parameter int unsigned RED_RED_CYCLES = 32000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic red1,
  output logic yellow1,
  output logic green1,
  output logic red2,
  output logic yellow2,
  output logic green2
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // dir1 red,    dir2 green
    S1 = 3'd1,  // dir1 red,    dir2 yellow
    S2 = 3'd2,  // all red
    S3 = 3'd3,  // dir1 green,  dir2 red
    S4 = 3'd4,  // dir1 yellow, dir2 red
    S5 = 3'd5   // all red
  } state_t;

  // Terminal counter value per phase; a zero duration collapses to a one-cycle phase.
  localparam logic [31:0] GREEN_LAST   = (GREEN_CYCLES   == 0) ? 32'd0 : GREEN_CYCLES   - 32'd1;
  localparam logic [31:0] YELLOW_LAST  = (YELLOW_CYCLES  == 0) ? 32'd0 : YELLOW_CYCLES  - 32'd1;
  localparam logic [31:0] RED_RED_LAST = (RED_RED_CYCLES == 0) ? 32'd0 : RED_RED_CYCLES - 32'd1;

  // Power-up values match the reset values so the block runs with rst_n tied high.
  state_t      state = S0;
  logic [31:0] cnt   = 32'd0;
  state_t      state_nxt;
  logic [31:0] cnt_nxt;
  logic [31:0] cnt_last;

  // State and dwell-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S0;
      cnt   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: hold until the counter reaches the phase's last cycle, then advance and clear.
  always_comb begin
    state_nxt = S0;
    cnt_nxt   = 32'd0;
    cnt_last  = 32'd0;
    case (state)
      S0, S3:  cnt_last = GREEN_LAST;
      S1, S4:  cnt_last = YELLOW_LAST;
      S2, S5:  cnt_last = RED_RED_LAST;
      default: cnt_last = 32'd0;
    endcase
    case (state)
      S0: state_nxt = (cnt == cnt_last) ? S1 : S0;
      S1: state_nxt = (cnt == cnt_last) ? S2 : S1;
      S2: state_nxt = (cnt == cnt_last) ? S3 : S2;
      S3: state_nxt = (cnt == cnt_last) ? S4 : S3;
      S4: state_nxt = (cnt == cnt_last) ? S5 : S4;
      S5: state_nxt = (cnt == cnt_last) ? S0 : S5;
      default: state_nxt = S0;
    endcase
    // Illegal encodings fall through to S0 with the counter cleared.
    if ((state == S0) || (state == S1) || (state == S2) ||
        (state == S3) || (state == S4) || (state == S5)) begin
      cnt_nxt = (cnt == cnt_last) ? 32'd0 : cnt + 32'd1;
    end
  end

  // Lamp decode from the state register only; illegal encodings show the S0 pattern.
  always_comb begin
    red1    = 1'b1;
    yellow1 = 1'b0;
    green1  = 1'b0;
    red2    = 1'b0;
    yellow2 = 1'b0;
    green2  = 1'b1;
    case (state)
      S1: begin
        green2  = 1'b0;
        yellow2 = 1'b1;
      end
      S2, S5: begin
        green2 = 1'b0;
        red2   = 1'b1;
      end
      S3: begin
        red1   = 1'b0;
        green1 = 1'b1;
        green2 = 1'b0;
        red2   = 1'b1;
      end
      S4: begin
        red1    = 1'b0;
        yellow1 = 1'b1;
        green2  = 1'b0;
        red2    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
`timescale 1ns/1ps
module tb_traffic_light;

  logic clk = 1'b0;
  logic rst_n;
  int   checks;
  int   errors;
  int unsigned e;  // rising edges seen since reset release (or time 0)

  logic r1, y1, g1, r2, y2, g2;
  logic fr1, fy1, fg1, fr2, fy2, fg2;
  logic zr1, zy1, zg1, zr2, zy2, zg2;
  logic [5:0] lamps_m, lamps_f, lamps_z;

  localparam logic [5:0] P_S0 = 6'b100_001;
  localparam logic [5:0] P_S1 = 6'b100_010;
  localparam logic [5:0] P_RR = 6'b100_100;
  localparam logic [5:0] P_S3 = 6'b001_100;
  localparam logic [5:0] P_S4 = 6'b010_100;

  always #31.25 clk = ~clk;

  traffic_light #(.GREEN_CYCLES(30), .YELLOW_CYCLES(5), .RED_RED_CYCLES(2)) u_main (
    .clk(clk), .rst_n(rst_n),
    .red1(r1), .yellow1(y1), .green1(g1), .red2(r2), .yellow2(y2), .green2(g2)
  );

  traffic_light #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .RED_RED_CYCLES(1)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .red1(fr1), .yellow1(fy1), .green1(fg1), .red2(fr2), .yellow2(fy2), .green2(fg2)
  );

  traffic_light #(.GREEN_CYCLES(0), .YELLOW_CYCLES(0), .RED_RED_CYCLES(0)) u_zero (
    .clk(clk), .rst_n(rst_n),
    .red1(zr1), .yellow1(zy1), .green1(zg1), .red2(zr2), .yellow2(zy2), .green2(zg2)
  );

  assign lamps_m = {r1, y1, g1, r2, y2, g2};
  assign lamps_f = {fr1, fy1, fg1, fr2, fy2, fg2};
  assign lamps_z = {zr1, zy1, zg1, zr2, zy2, zg2};

  // Elapsed-time reference: edges only count while out of reset.
  initial e = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  // Reference: lamp pattern after a given number of edges, from phase durations.
  function automatic logic [5:0] model_lamps(input int unsigned edges, input int unsigned g,
                                             input int unsigned y, input int unsigned r);
    int unsigned d[6];
    logic [5:0]  pats[6];
    int unsigned per;
    int unsigned p;
    if (g == 0) g = 1;
    if (y == 0) y = 1;
    if (r == 0) r = 1;
    d    = '{g, y, r, g, y, r};
    pats = '{P_S0, P_S1, P_RR, P_S3, P_S4, P_RR};
    per  = 2 * (g + y + r);
    p    = edges % per;
    for (int i = 0; i < 6; i++) begin
      if (p < d[i]) return pats[i];
      p = p - d[i];
    end
    return P_S0;
  endfunction

  function automatic int unsigned dwell_of(input logic [5:0] pat);
    if (pat == P_S0 || pat == P_S3) return 30;
    if (pat == P_S1 || pat == P_S4) return 5;
    return 2;
  endfunction

  task automatic test_reset();
    #10;
    checks++;
    if (lamps_m !== P_S0) begin
      errors++;
      $display("FAIL powerup_main got %b want %b", lamps_m, P_S0);
    end
    checks++;
    if (lamps_f !== P_S0) begin
      errors++;
      $display("FAIL powerup_fast got %b want %b", lamps_f, P_S0);
    end
    checks++;
    if (lamps_z !== P_S0) begin
      errors++;
      $display("FAIL powerup_zero got %b want %b", lamps_z, P_S0);
    end
  endtask

  task automatic test_fast_params();
    logic [5:0] seq[6];
    seq = '{P_S0, P_S1, P_RR, P_S3, P_S4, P_RR};
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (lamps_f !== seq[k % 6]) begin
        errors++;
        $display("FAIL fast_step%0d got %b want %b", k, lamps_f, seq[k % 6]);
      end
      checks++;
      if (lamps_z !== seq[k % 6]) begin
        errors++;
        $display("FAIL zero_step%0d got %b want %b", k, lamps_z, seq[k % 6]);
      end
    end
  endtask

  task automatic test_schedule();
    int unsigned tgt[8];
    logic [5:0]  exp[8];
    int          guard;
    tgt = '{31, 36, 38, 68, 73, 75, 103, 104};
    exp = '{P_S1, P_RR, P_S3, P_S4, P_RR, P_S0, P_S0, P_S1};
    for (int i = 0; i < 8; i++) begin
      guard = 0;
      while (e < tgt[i] && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (e != tgt[i]) begin
        errors++;
        $display("FAIL sched_wait edges %0d want %0d", e, tgt[i]);
      end
      checks++;
      if (lamps_m !== exp[i]) begin
        errors++;
        $display("FAIL sched_edge%0d got %b want %b", tgt[i], lamps_m, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_phase();
    int guard;
    guard = 0;
    while ((e % 74) != 50 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (lamps_m !== P_S3) begin
      errors++;
      $display("FAIL midrst_pre got %b want %b", lamps_m, P_S3);
    end
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if (lamps_m !== P_S0) begin
      errors++;
      $display("FAIL midrst_async got %b want %b", lamps_m, P_S0);
    end
    #9 rst_n = 1'b1;
    #1;
    checks++;
    if (lamps_m !== P_S0) begin
      errors++;
      $display("FAIL midrst_release got %b want %b", lamps_m, P_S0);
    end
    guard = 0;
    while (e < 29 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (e != 29 || lamps_m !== P_S0) begin
      errors++;
      $display("FAIL midrst_s0_hold edges %0d got %b want %b", e, lamps_m, P_S0);
    end
    @(negedge clk);
    checks++;
    if (e != 30 || lamps_m !== P_S1) begin
      errors++;
      $display("FAIL midrst_s0_end edges %0d got %b want %b", e, lamps_m, P_S1);
    end
  endtask

  task automatic test_random();
    logic [5:0]  run_pat;
    int unsigned run_len;
    bit          run_clean;
    logic [5:0]  exp;
    int unsigned off, wid, hold;
    run_pat   = lamps_m;
    run_len   = 0;
    run_clean = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      exp = model_lamps(e, 30, 5, 2);
      checks++;
      if (lamps_m !== exp) begin
        errors++;
        $display("FAIL rand_main cyc%0d edges %0d got %b want %b", c, e, lamps_m, exp);
      end
      exp = model_lamps(e, 1, 1, 1);
      checks++;
      if (lamps_f !== exp || lamps_z !== exp) begin
        errors++;
        $display("FAIL rand_fast cyc%0d got %b/%b want %b", c, lamps_f, lamps_z, exp);
      end
      checks++;
      if ($countones(lamps_m[5:3]) != 1 || $countones(lamps_m[2:0]) != 1 ||
          (!lamps_m[5] && !lamps_m[2])) begin
        errors++;
        $display("FAIL rand_safety cyc%0d got %b want one-hot per dir, one red", c, lamps_m);
      end
      if (lamps_m === run_pat) begin
        run_len++;
      end else begin
        if (run_clean) begin
          checks++;
          if (run_len != dwell_of(run_pat)) begin
            errors++;
            $display("FAIL rand_dwell pat %b got %0d want %0d", run_pat, run_len, dwell_of(run_pat));
          end
        end
        run_pat   = lamps_m;
        run_len   = 1;
        run_clean = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        run_clean = 1'b0;
        off = $urandom_range(2, 10);
        wid = $urandom_range(1, 12);
        #(off) rst_n = 1'b0;
        #1;
        checks++;
        if (lamps_m !== P_S0) begin
          errors++;
          $display("FAIL rand_rst_async got %b want %b", lamps_m, P_S0);
        end
        hold = $urandom_range(0, 3);
        if (hold == 0) begin
          #(wid) rst_n = 1'b1;
        end else begin
          for (int h = 0; h < int'(hold); h++) begin
            @(negedge clk);
            checks++;
            if (lamps_m !== P_S0) begin
              errors++;
              $display("FAIL rand_rst_hold got %b want %b", lamps_m, P_S0);
            end
          end
          #5 rst_n = 1'b1;
        end
        run_pat = lamps_m;
        run_len = 0;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    checks = 0;
    errors = 0;
    test_reset();
    test_fast_params();
    test_schedule();
    test_reset_mid_phase();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
